// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared widths and FSM state encoding for the PC sequencer
package pc_seq_pkg;
  localparam int PC_W  = 12;
  localparam int DEPTH = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// ret_stack: DEPTH x W return-address LIFO
// clk_i/rst_i: clock, async active-high reset; push_i/pop_i/clr_i: stack ops
// data_i: value to push; top_o: most recent entry; full_o/empty_o: occupancy flags
module ret_stack import pc_seq_pkg::*; #(
  parameter int W = PC_W,
  parameter int D = DEPTH
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         clr_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] top_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(D);
  localparam int CW = $clog2(D + 1);
  logic [W-1:0]  mem [D];
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] idx, idx_m1;
  assign idx     = cnt_q[AW-1:0];
  assign idx_m1  = idx - AW'(1);
  assign top_o   = mem[idx_m1];
  assign full_o  = cnt_q == CW'(D);
  assign empty_o = cnt_q == '0;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (push_i && !full_o) cnt_q <= cnt_q + CW'(1);
    else if (pop_i && !empty_o) cnt_q <= cnt_q - CW'(1);
  always_ff @(posedge clk_i)
    if (push_i && !full_o && !clr_i) mem[idx] <= data_i;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter, branch/call/return sequencing and run handshake
// Clk/Reset: clock, async active-high reset; Start: launch at address 0; Stall: freeze
// Branch/Cond/Call/Ret/Halt/Target: decoder controls and jump target
// ProgCtr: fetch address; Running/Done: run status; StackErr: sticky stack fault
module pc_sequencer import pc_seq_pkg::*; (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Stall,
  input  logic            Branch,
  input  logic            Cond,
  input  logic            Call,
  input  logic            Ret,
  input  logic            Halt,
  input  logic [PC_W-1:0] Target,
  output logic [PC_W-1:0] ProgCtr,
  output logic            Running,
  output logic            Done,
  output logic            StackErr
);
  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc, top;
  logic            err_q, err_d, running_q, done_q;
  logic            push, pop, clr, full, empty;
  assign pc_inc   = pc_q + PC_W'(1);
  assign ProgCtr  = pc_q;
  assign Running  = running_q;
  assign Done     = done_q;
  assign StackErr = err_q;
  ret_stack u_stack (
    .clk_i(Clk), .rst_i(Reset), .push_i(push), .pop_i(pop), .clr_i(clr),
    .data_i(pc_inc), .top_o(top), .full_o(full), .empty_o(empty)
  );
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    push    = 1'b0;
    pop     = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      RUN: if (!Stall) begin
        if (Halt) state_d = DONE;
        else if (Ret) begin
          pop   = !empty;
          pc_d  = empty ? pc_inc : top;
          err_d = err_q | empty;
        end else if (Call) begin
          push  = !full;
          pc_d  = full ? pc_inc : Target;
          err_d = err_q | full;
        end else pc_d = (Branch && Cond) ? Target : pc_inc;
      end
      default: if (Start) begin
        state_d = RUN;
        pc_d    = '0;
        err_d   = 1'b0;
        clr     = 1'b1;
      end
    endcase
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      err_q     <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      err_q     <= err_d;
      running_q <= state_d == RUN;
      done_q    <= state_d == DONE;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer
module tb_pc_sequencer;
  logic        Clk = 1'b0, Reset = 1'b1;
  logic        Start = 0, Stall = 0, Branch = 0, Cond = 0, Call = 0, Ret = 0, Halt = 0;
  logic [11:0] Target = '0;
  logic [11:0] ProgCtr;
  logic        Running, Done, StackErr;
  int          n_chk = 0, n_err = 0;

  pc_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .Branch(Branch),
    .Cond(Cond), .Call(Call), .Ret(Ret), .Halt(Halt), .Target(Target),
    .ProgCtr(ProgCtr), .Running(Running), .Done(Done), .StackErr(StackErr)
  );

  always #5 Clk = ~Clk;

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    Start = 0; Stall = 0; Branch = 0; Cond = 0; Call = 0; Ret = 0; Halt = 0; Target = '0;
  endtask

  task automatic chk_st(input string tag, input logic [11:0] pc, input logic r, input logic d, input logic e);
    chk({tag, "_pc"}, ProgCtr, pc);
    chk({tag, "_run"}, Running, r);
    chk({tag, "_done"}, Done, d);
    chk({tag, "_err"}, StackErr, e);
  endtask

  initial begin
    #2;
    chk_st("reset", 0, 0, 0, 0);
    #5 Reset = 0;
    cyc();
    chk_st("idle", 0, 0, 0, 0);
    Start = 1; cyc(); Start = 0;
    chk_st("start", 0, 1, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      chk_st($sformatf("inc%0d", i), 12'(i), 1, 0, 0);
    end
    Start = 1; cyc(); Start = 0;
    chk("start_in_run", ProgCtr, 6);
    Stall = 1; cyc(); Stall = 0;
    chk("stall_hold", ProgCtr, 6);
    cyc(); cyc(); cyc();
    chk("pc9", ProgCtr, 9);
    Branch = 1; Cond = 1; Target = 38; cyc();
    chk("br_taken", ProgCtr, 38);
    Target = 9; cyc();
    chk("br_back", ProgCtr, 9);
    Cond = 0; Target = 38; cyc();
    chk("br_not_taken", ProgCtr, 10);
    Cond = 1; Target = 20; cyc(); clr_in();
    chk("pc20", ProgCtr, 20);
    Call = 1; Target = 83; cyc(); clr_in();
    chk("call83", ProgCtr, 83);
    cyc(); chk("pc84", ProgCtr, 84);
    cyc(); chk("pc85", ProgCtr, 85);
    Ret = 1; cyc(); clr_in();
    chk("ret21", ProgCtr, 21);
    chk("ret_no_err", StackErr, 0);
    Call = 1;
    Target = 100; cyc(); chk("nest1", ProgCtr, 100);
    Target = 110; cyc(); chk("nest2", ProgCtr, 110);
    Target = 120; cyc(); chk("nest3", ProgCtr, 120);
    Target = 130; cyc(); chk("nest4", ProgCtr, 130);
    chk("full_no_err", StackErr, 0);
    Target = 140; cyc(); clr_in();
    chk("overflow_pc", ProgCtr, 131);
    chk("overflow_err", StackErr, 1);
    Ret = 1;
    cyc(); chk("pop4", ProgCtr, 121);
    cyc(); chk("pop3", ProgCtr, 111);
    cyc(); chk("pop2", ProgCtr, 101);
    cyc(); chk("pop1", ProgCtr, 22);
    clr_in();
    Branch = 1; Cond = 1; Target = 200; cyc(); clr_in();
    chk("pc200", ProgCtr, 200);
    Halt = 1; Stall = 1; cyc();
    chk_st("halt_stalled", 200, 1, 0, 1);
    Stall = 0; cyc(); clr_in();
    chk_st("halted", 200, 0, 1, 1);
    Branch = 1; Cond = 1; Target = 7; cyc(); clr_in();
    chk_st("done_hold", 200, 0, 1, 1);
    Start = 1; cyc(); clr_in();
    chk_st("restart", 0, 1, 0, 0);
    Ret = 1; cyc(); clr_in();
    chk("underflow_pc", ProgCtr, 1);
    chk("underflow_err", StackErr, 1);
    Branch = 1; Cond = 1; Target = 12'd4095; cyc(); clr_in();
    chk("pc4095", ProgCtr, 4095);
    cyc();
    chk("wrap", ProgCtr, 0);
    Branch = 1; Cond = 1; Target = 12'd4095; cyc(); clr_in();
    Call = 1; Target = 50; cyc(); clr_in();
    chk("call_at_max", ProgCtr, 50);
    Ret = 1; cyc(); clr_in();
    chk("ret_wrapped", ProgCtr, 0);
    Branch = 1; Cond = 1; Target = 70; cyc(); clr_in();
    Call = 1; Target = 60; cyc(); clr_in();
    chk("call60", ProgCtr, 60);
    #2 Reset = 1;
    #1 chk_st("async_reset", 0, 0, 0, 0);
    #1 Reset = 0;
    cyc();
    chk_st("post_reset_idle", 0, 0, 0, 0);
    Start = 1; cyc(); clr_in();
    Ret = 1; cyc(); clr_in();
    chk("stack_discarded_pc", ProgCtr, 1);
    chk("stack_discarded_err", StackErr, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and fetch-sequencing stage that consumes the 12-bit jump target produced by the jump lookup table and drives the instruction-memory address. It holds the PC and advances it by increment, taken branch, call or return. It also provides a 4-deep return-address stack and the Start/Done run handshake to the testbench. It sits between the decoder/LUT (upstream) and instruction ROM (downstream).

## Interface
- PC_W, 12, PC / jump-target width (matches jump LUT output)
- DEPTH, 4, return-stack entries (power of two)
- Clk  in  1  sole clock, rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- Start  in  1  one-cycle pulse; launches program at address 0
- Stall  in  1  freeze PC, stack and state this cycle
- Branch  in  1  decoder: conditional-branch instruction
- Cond  in  1  branch condition flag (taken when Branch & Cond)
- Call  in  1  decoder: call instruction
- Ret  in  1  decoder: return instruction
- Halt  in  1  decoder: end-of-program instruction
- Target  in  PC_W  absolute destination from jump LUT, valid same cycle
- ProgCtr  out  PC_W  instruction-memory address
- Running  out  1  high in RUN
- Done  out  1  high in DONE (program finished)
- StackErr  out  1  sticky: overflow or underflow occurred

## Operation
- FSM states: IDLE, RUN, DONE. Reset -> IDLE; ProgCtr=0, Running=0, Done=0, StackErr=0, stack empty.
- IDLE: Start -> RUN, ProgCtr=0. Other inputs ignored.
- RUN, Stall=1: hold everything (including Halt/Start).
- RUN, Stall=0, one action, priority Halt > Ret > Call > taken Branch > increment:
  - Halt: -> DONE, ProgCtr holds (address of Halt instruction).
  - Ret, stack non-empty: ProgCtr <= top; pop.
  - Ret, stack empty: ProgCtr <= ProgCtr+1; StackErr <= 1.
  - Call, stack not full: push ProgCtr+1; ProgCtr <= Target.
  - Call, stack full: no push, ProgCtr <= ProgCtr+1; StackErr <= 1.
  - Branch & Cond: ProgCtr <= Target. Branch & !Cond: increment.
  - default: ProgCtr <= ProgCtr+1, modulo 2^PC_W (4095 -> 0, no error).
- RUN, Start: ignored.
- DONE: ProgCtr, Done held; Start -> RUN, ProgCtr=0, stack emptied, StackErr cleared.
- Stack: LIFO, PC_W-bit entries, count 0..DEPTH; push/pop never simultaneous.

## Timing
- All outputs registered; change only on Clk rising edge or Reset assertion.
- Branch/Call/Ret/Halt/Target sampled on the edge where ProgCtr addresses that instruction; new ProgCtr visible next cycle (1-cycle redirect, no delay slot).
- Start in IDLE/DONE at edge N -> Running=1, ProgCtr=0 after edge N.
- Halt accepted at edge N -> Running=0, Done=1 after edge N.
- Reset mid-RUN: immediate return to IDLE values, stack contents discarded.
- Pushed value = ProgCtr+1, wraps identically to increment.

## Structure
- Package pc_seq_pkg: PC_W, DEPTH localparams, state_t enum {IDLE, RUN, DONE}.
- Sub-module ret_stack: DEPTH x PC_W LIFO with push, pop, clear, top, full, empty; async Reset.
- Top holds FSM, PC register, priority mux, StackErr flag.

## Test plan
- Reset, Start, 5 idle cycles -> ProgCtr 0,1,2,3,4,5; Running=1, Done=0.
- At PC=9 Branch=1, Cond=1, Target=38 -> next ProgCtr=38; same with Cond=0 -> 10.
- At PC=20 Call, Target=83; at PC=85 Ret -> sequence 20,83,84,85,21.
- Five nested Calls (DEPTH=4) -> 5th not taken, PC increments, StackErr=1; Ret on empty stack likewise sets StackErr.
- Halt at PC=200 with Stall=1 one cycle, then Stall=0 -> PC stays 200, Done=1 after release; Start -> ProgCtr=0, StackErr=0.
- Reset asserted mid-RUN between edges -> outputs 0 immediately; PC 4095 increment -> 0.
